// File: rtl/seq_ctrl_pkg.sv
// Shared types, default sizes and a debug helper for the serial pattern detector.
package seq_ctrl_pkg;

  localparam int unsigned DefWordW = 8;
  localparam int unsigned DefPatW  = 5;
  localparam int unsigned DefCntW  = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    SHIFT     = 2'd2,
    HALT      = 2'd3
  } state_t;

  // ASCII state name, nine characters wide, for debug displays.
  function automatic logic [8*9-1:0] state_name(input state_t s);
    logic [8*9-1:0] name;
    case (s)
      IDLE:      name = "IDLE     ";
      WAIT_WORD: name = "WAIT_WORD";
      SHIFT:     name = "SHIFT    ";
      HALT:      name = "HALT     ";
      default:   name = "UNKNOWN  ";
    endcase
    return name;
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Serial pattern matcher: bit history, fill counter, length-masked compare, overlap clear.
module seq_match_core
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned PAT_W = DefPatW,
  parameter int unsigned LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic             clear,
  input  logic [LEN_W-1:0] len,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             match
);

  // Only PAT_W-1 past bits are kept: together with bit_in they form the full compare window,
  // and the oldest bit of a full window is never looked at again.
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;

  logic [PAT_W-1:0] hist_shift;
  logic [LEN_W-1:0] fill_inc;
  logic [PAT_W-1:0] len_mask;

  // Compare the updated history against the pattern, masked to the programmed length.
  always_comb begin
    hist_shift = {hist_q, bit_in};
    fill_inc   = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
    len_mask   = '0;
    for (int i = 0; i < int'(PAT_W); i++) begin
      len_mask[i] = (LEN_W'(i) < len);
    end
    match = shift_en && (len != '0) && (fill_inc >= len) &&
            (((hist_shift ^ pattern) & len_mask) == '0);
  end

  // Next history: clear wins, then non-overlapped match restart, else shift in the new bit.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en) begin
      if (match && !overlap) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = hist_shift[PAT_W-2:0];
        fill_d = fill_inc;
      end
    end
  end

  // History and fill registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Word-to-bit scheduler and controller around the serial pattern matcher.
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned WORD_W = DefWordW,
  parameter int unsigned PAT_W  = DefPatW,
  parameter int unsigned CNT_W  = DefCntW,
  parameter int unsigned LEN_W  = $clog2(PAT_W + 1)
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              start,
  input  logic              stop,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNT_W-1:0]  cfg_thresh,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  output logic              s_ready,
  output logic              busy,
  output logic              det_pulse,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic              irq,
  input  logic              irq_clr
);

  localparam int unsigned BitW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_t state_q, state_d;

  logic [WORD_W-1:0] word_q, word_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              ovl_q, ovl_d;
  logic [CNT_W-1:0]  thr_q, thr_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic              irq_q, irq_d;
  logic              det_q, det_d;

  logic              core_shift;
  logic              core_clear;
  logic              core_match;
  logic [CNT_W-1:0]  hit_inc;

  // A stop in the same cycle suppresses the shift, so any match on this bit is dropped.
  assign core_shift = (state_q == SHIFT) && !stop;

  seq_match_core #(
    .PAT_W(PAT_W),
    .LEN_W(LEN_W)
  ) u_core (
    .clk     (clk),
    .res_n   (res_n),
    .shift_en(core_shift),
    .bit_in  (word_q[WORD_W-1]),
    .clear   (core_clear),
    .len     (len_q),
    .pattern (pat_q),
    .overlap (ovl_q),
    .match   (core_match)
  );

  // FSM next state, word serialization, hit counting and irq control.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    bit_cnt_d  = bit_cnt_q;
    pat_d      = pat_q;
    len_d      = len_q;
    ovl_d      = ovl_q;
    thr_d      = thr_q;
    hit_cnt_d  = hit_cnt_q;
    irq_d      = irq_q;
    det_d      = 1'b0;
    core_clear = 1'b0;
    hit_inc    = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + 1'b1;

    if (irq_clr) begin
      irq_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          pat_d      = cfg_pattern;
          len_d      = (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;
          ovl_d      = cfg_overlap;
          thr_d      = cfg_thresh;
          hit_cnt_d  = '0;
          core_clear = 1'b1;
          state_d    = WAIT_WORD;
        end
      end
      WAIT_WORD: begin
        if (s_valid) begin
          word_d    = s_data;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        word_d    = {word_q[WORD_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BitW'(WORD_W - 1)) begin
          state_d = WAIT_WORD;
        end
        if (core_match) begin
          det_d     = 1'b1;
          hit_cnt_d = hit_inc;
          // Reaching the threshold abandons the rest of the word; set beats irq_clr.
          if ((thr_q != '0) && (hit_inc == thr_q)) begin
            irq_d   = 1'b1;
            state_d = HALT;
          end
        end
      end
      HALT: begin
        if (irq_clr) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort from any active state; the in-flight word is dropped, counts are kept.
    if (stop && (state_q != IDLE)) begin
      state_d    = IDLE;
      core_clear = 1'b1;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q   <= IDLE;
      word_q    <= '0;
      bit_cnt_q <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      thr_q     <= '0;
      hit_cnt_q <= '0;
      irq_q     <= 1'b0;
      det_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      bit_cnt_q <= bit_cnt_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      thr_q     <= thr_d;
      hit_cnt_q <= hit_cnt_d;
      irq_q     <= irq_d;
      det_q     <= det_d;
    end
  end

  assign s_ready   = (state_q == WAIT_WORD);
  assign busy      = (state_q != IDLE);
  assign det_pulse = det_q;
  assign hit_cnt   = hit_cnt_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed self-checking bench for seq_detect_ctrl.
module tb_seq_detect_ctrl;
  import seq_ctrl_pkg::*;

  localparam int WORD_W = 8;
  localparam int PAT_W  = 5;
  localparam int CNT_W  = 8;
  localparam int LEN_W  = 3;

  logic              clk = 1'b0;
  logic              res_n = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [PAT_W-1:0]  cfg_pattern = '0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic              cfg_overlap = 1'b0;
  logic [CNT_W-1:0]  cfg_thresh = '0;
  logic              s_valid = 1'b0;
  logic [WORD_W-1:0] s_data = '0;
  logic              s_ready;
  logic              busy;
  logic              det_pulse;
  logic [CNT_W-1:0]  hit_cnt;
  logic              irq;
  logic              irq_clr = 1'b0;

  seq_detect_ctrl dut (
    .clk        (clk),
    .res_n      (res_n),
    .start      (start),
    .stop       (stop),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cfg_thresh (cfg_thresh),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .busy       (busy),
    .det_pulse  (det_pulse),
    .hit_cnt    (hit_cnt),
    .irq        (irq),
    .irq_clr    (irq_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc;
  int hs;
  int first_irq;
  int stop_at;
  int clr_at;
  int det_q[$];
  int rdy_q[$];
  logic [WORD_W-1:0] words[$];

  // One clock: wait for the falling edge, then log what the DUT shows.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (det_pulse) det_q.push_back(cyc);
    if (s_ready) rdy_q.push_back(cyc);
    if (irq && first_irq < 0) first_irq = cyc;
  endtask

  // Drive start with the given config; the following run() takes it from there.
  task automatic begin_run(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                           input logic ovl, input logic [CNT_W-1:0] thr);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_thresh  = thr;
    start       = 1'b1;
    cyc         = 0;
    hs          = 0;
    first_irq   = -1;
    stop_at     = -1;
    clr_at      = -1;
    det_q.delete();
    rdy_q.delete();
  endtask

  // Present the queued words through the handshake for n cycles.
  task automatic run(input int n);
    int  idx;
    bit  pend;
    idx  = 0;
    pend = 1'b0;
    s_valid = (words.size() > 0);
    if (words.size() > 0) s_data = words[0];
    for (int c = 0; c < n; c++) begin
      step();
      start = 1'b0;
      if (pend) begin
        idx++;
        if (idx < words.size()) s_data = words[idx];
        else s_valid = 1'b0;
      end
      pend = s_ready && s_valid;
      if (pend) hs++;
      stop    = (cyc == stop_at);
      irq_clr = (cyc == clr_at);
    end
    stop    = 1'b0;
    irq_clr = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic go_idle();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    #1 res_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_ready, busy, det_pulse, hit_cnt, irq} !== '0)
      $display("FAIL reset_outputs: got ready=%b busy=%b det=%b hit=%0d irq=%b, want all 0",
               s_ready, busy, det_pulse, hit_cnt, irq);
    else passes++;
    res_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_overlap();
    words = '{8'hBB, 8'hC0};
    begin_run(5'b10111, 3'd5, 1'b1, 8'd0);
    run(22);
    checks++;
    if (det_q.size() != 2 || det_q[0] != 7 || det_q[1] != 12)
      $display("FAIL ovl_det_pos: got %0d pulses (first at %0d), want 2 at cycles 7,12",
               det_q.size(), (det_q.size() > 0) ? det_q[0] : -1);
    else passes++;
    checks++;
    if (hit_cnt !== 8'd2) $display("FAIL ovl_hit_cnt: got %0d want 2", hit_cnt);
    else passes++;
    checks++;
    if (rdy_q.size() < 2 || rdy_q[0] != 1 || rdy_q[1] != 10)
      $display("FAIL ovl_ready_gap: got %0d ready cycles (second at %0d), want 1 then 10",
               rdy_q.size(), (rdy_q.size() > 1) ? rdy_q[1] : -1);
    else passes++;
    checks++;
    if (hs != 2) $display("FAIL ovl_handshakes: got %0d want 2", hs);
    else passes++;
    go_idle();
  endtask

  task automatic test_non_overlap();
    words = '{8'hBB, 8'hC0};
    begin_run(5'b10111, 3'd5, 1'b0, 8'd0);
    run(22);
    checks++;
    if (det_q.size() != 1 || det_q[0] != 7)
      $display("FAIL novl_det_pos: got %0d pulses, want 1 at cycle 7", det_q.size());
    else passes++;
    checks++;
    if (hit_cnt !== 8'd1) $display("FAIL novl_hit_cnt: got %0d want 1", hit_cnt);
    else passes++;
    go_idle();
  endtask

  task automatic test_threshold();
    words = '{8'hBB, 8'hFF};
    begin_run(5'b10111, 3'd5, 1'b1, 8'd1);
    run(20);
    checks++;
    if (first_irq != 7) $display("FAIL thr_irq_cycle: got %0d want 7", first_irq);
    else passes++;
    checks++;
    if (dut.state_q !== HALT)
      $display("FAIL thr_state: got %0s want %0s", state_name(dut.state_q), state_name(HALT));
    else passes++;
    checks++;
    if (hs != 1 || rdy_q.size() != 1)
      $display("FAIL thr_no_accept: got %0d handshakes %0d ready cycles, want 1 and 1",
               hs, rdy_q.size());
    else passes++;
    checks++;
    if (det_q.size() != 1 || hit_cnt !== 8'd1 || irq !== 1'b1)
      $display("FAIL thr_halted: got %0d pulses hit=%0d irq=%b, want 1 1 1",
               det_q.size(), hit_cnt, irq);
    else passes++;
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    checks++;
    if (busy !== 1'b0 || irq !== 1'b0 || hit_cnt !== 8'd1)
      $display("FAIL thr_release: got busy=%b irq=%b hit=%0d, want 0 0 1", busy, irq, hit_cnt);
    else passes++;
  endtask

  task automatic test_saturate_clamp();
    words.delete();
    for (int i = 0; i < 40; i++) words.push_back(8'hFF);
    begin_run(5'b00001, 3'd1, 1'b1, 8'd0);
    run(363);
    checks++;
    if (hs != 40 || det_q.size() != 320)
      $display("FAIL sat_pulses: got %0d words %0d pulses, want 40 320", hs, det_q.size());
    else passes++;
    checks++;
    if (hit_cnt !== 8'd255) $display("FAIL sat_hit_cnt: got %0d want 255", hit_cnt);
    else passes++;
    go_idle();
    words = '{8'hBB, 8'hC0};
    begin_run(5'b10111, 3'd7, 1'b1, 8'd0);
    run(22);
    checks++;
    if (det_q.size() != 2 || hit_cnt !== 8'd2)
      $display("FAIL clamp_len7: got %0d pulses hit=%0d, want 2 2", det_q.size(), hit_cnt);
    else passes++;
    go_idle();
  endtask

  task automatic test_stop_reset();
    words = '{8'hFF};
    begin_run(5'b00001, 3'd1, 1'b1, 8'd0);
    stop_at = 4;
    run(5);
    checks++;
    if (busy !== 1'b0 || hit_cnt !== 8'd2 || det_q.size() != 2 || det_pulse !== 1'b0)
      $display("FAIL stop_mid_word: got busy=%b hit=%0d pulses=%0d det=%b, want 0 2 2 0",
               busy, hit_cnt, det_q.size(), det_pulse);
    else passes++;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (hit_cnt !== 8'd0 || s_ready !== 1'b1)
      $display("FAIL restart_clear: got hit=%0d ready=%b, want 0 1", hit_cnt, s_ready);
    else passes++;
    go_idle();
    words = '{8'hFF};
    begin_run(5'b00001, 3'd1, 1'b1, 8'd0);
    run(4);
    #2 res_n = 1'b0;
    #1;
    checks++;
    if ({s_ready, busy, det_pulse, hit_cnt, irq} !== '0)
      $display("FAIL async_reset: got ready=%b busy=%b det=%b hit=%0d irq=%b, want all 0",
               s_ready, busy, det_pulse, hit_cnt, irq);
    else passes++;
    @(negedge clk);
    res_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    words = '{8'hBB};
    begin_run(5'b10111, 3'd5, 1'b1, 8'd1);
    clr_at = 6;
    run(10);
    checks++;
    if (first_irq != 7 || irq !== 1'b1 || dut.state_q !== HALT)
      $display("FAIL set_beats_clr: got irq_cycle=%0d irq=%b state=%0s, want 7 1 HALT",
               first_irq, irq, state_name(dut.state_q));
    else passes++;
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0)
      $display("FAIL start_stop_idle: got busy=%b ready=%b, want 0 0", busy, s_ready);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_threshold();
    test_saturate_clamp();
    test_stop_reset();
    test_simultaneous();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
